// File: rtl/memory_if.sv
// Data-bus handshake between the memory stage (master) and the data memory
// or cache (slave). A request is held stable until dresp_addr_ok, and
// dresp_data_ok marks returned load data or a completed store.
interface memory_if;
    logic        dreq_valid;
    logic        dreq_write;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory.sv
// Memory-access stage of the five-stage MIPS pipeline. It registers the
// execute->memory bundle, runs the lw/sw bus handshake, resolves branches,
// and feeds forwarding/hazard information back up the pipe.

package pipes;
    typedef logic [31:0] u32;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        u32         pc_plus_4;
        u32         alu_result;
        u32         write_data;
        creg_addr_t write_reg;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       zero;
        u32         pc_branch;
    } e_m_reg_t;

    typedef struct packed {
        u32         pc_plus_4;
        u32         alu_result;
        u32         read_data;
        creg_addr_t write_reg;
        logic       reg_write;
        logic       mem_to_reg;
    } m_w_reg_t;
endpackage

module memory
    import pipes::*;
(
    input  logic            clk,
    input  logic            reset,
    input  e_m_reg_t        e_m_reg,
    input  logic            stall_m,
    input  logic            flush_m,
    memory_if.master        dbus,
    output m_w_reg_t        m_w_reg,
    output logic            pcsrc,
    output logic [31:0]     pc_branch,
    output logic [31:0]     aluout_fwd,
    output logic [4:0]      write_regM,
    output logic            reg_writeM,
    output logic            mem_busy,
    output logic            addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A bundle performs a bus access if it either loads or stores.
    function automatic logic is_memop(input e_m_reg_t x);
        return x.mem_to_reg | x.mem_write;
    endfunction

    // Word accesses only: any set bit in the low two address bits is an error.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    state_e      state_q, state_d;
    e_m_reg_t    m_q, m_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_s;
    logic        capture_s;
    logic        memop_s;
    logic        addr_err_s;

    // While a transaction is outstanding the stage must not accept new work.
    assign busy_s    = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign capture_s = !stall_m && !busy_s;

    // Next-state, pipeline-register and load-data computation.
    always_comb begin
        m_d     = m_q;
        state_d = state_q;
        rdata_d = rdata_q;
        if (capture_s) begin
            if (flush_m) begin
                m_d     = '0;
                state_d = ST_IDLE;
            end else begin
                m_d = e_m_reg;
                // A misaligned memop is captured but never reaches the bus.
                if (is_memop(e_m_reg) && !is_misaligned(e_m_reg.alu_result)) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (dbus.dresp_addr_ok) begin
                        if (dbus.dresp_data_ok) begin
                            state_d = ST_DONE;
                            rdata_d = dbus.dresp_data;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (dbus.dresp_data_ok) begin
                        state_d = ST_DONE;
                        rdata_d = dbus.dresp_data;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                // Stray data_ok here is ignored; hold until the next capture.
                ST_IDLE, ST_DONE: state_d = state_q;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // State, pipeline register and load data, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            rdata_q <= rdata_d;
        end
    end

    assign memop_s    = m_q.mem_to_reg | m_q.mem_write;
    assign addr_err_s = memop_s && is_misaligned(m_q.alu_result);

    // Output decode; everything is a function of registered state only.
    always_comb begin
        dbus.dreq_valid  = 1'b0;
        dbus.dreq_write  = 1'b0;
        dbus.dreq_addr   = 32'h0000_0000;
        dbus.dreq_strobe = 4'b0000;
        dbus.dreq_data   = 32'h0000_0000;
        if (state_q == ST_ADDR) begin
            dbus.dreq_valid  = 1'b1;
            dbus.dreq_write  = m_q.mem_write;
            dbus.dreq_addr   = m_q.alu_result;
            dbus.dreq_strobe = m_q.mem_write ? 4'b1111 : 4'b0000;
            dbus.dreq_data   = m_q.write_data;
        end else begin
            dbus.dreq_valid  = 1'b0;
        end

        m_w_reg.pc_plus_4  = m_q.pc_plus_4;
        m_w_reg.alu_result = m_q.alu_result;
        m_w_reg.read_data  = rdata_q;
        m_w_reg.write_reg  = m_q.write_reg;
        // A faulting access must not update the register file.
        m_w_reg.reg_write  = m_q.reg_write & ~addr_err_s;
        m_w_reg.mem_to_reg = m_q.mem_to_reg;

        pcsrc      = m_q.branch & m_q.zero;
        pc_branch  = m_q.pc_branch;
        aluout_fwd = m_q.alu_result;
        write_regM = m_q.write_reg;
        reg_writeM = m_q.reg_write;
        mem_busy   = busy_s;
        addr_err   = addr_err_s;
    end

endmodule

// File: tb/tb_memory.sv
// Bench for the memory stage: directed instructions, a configurable bus
// responder, and a scoreboard of expected bus requests and writeback bundles.
module tb_memory;
    import pipes::*;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  strobe;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] read_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_result;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset;
    e_m_reg_t    e_m_in;
    logic        stall_m;
    logic        flush_m;
    m_w_reg_t    m_w_reg;
    logic        pcsrc;
    logic [31:0] pc_branch;
    logic [31:0] aluout_fwd;
    logic [4:0]  write_regM;
    logic        reg_writeM;
    logic        mem_busy;
    logic        addr_err;

    memory_if bus ();

    memory dut (
        .clk        (clk),
        .reset      (reset),
        .e_m_reg    (e_m_in),
        .stall_m    (stall_m),
        .flush_m    (flush_m),
        .dbus       (bus.master),
        .m_w_reg    (m_w_reg),
        .pcsrc      (pcsrc),
        .pc_branch  (pc_branch),
        .aluout_fwd (aluout_fwd),
        .write_regM (write_regM),
        .reg_writeM (reg_writeM),
        .mem_busy   (mem_busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    req_t        exp_req[$];
    wb_t         exp_wb[$];
    int          addr_wait = 0;
    int          data_wait = 0;
    logic [31:0] rd_val = 32'h0;
    int          valid_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic e_m_reg_t mk(input logic [31:0] alu, input logic [31:0] wdata,
                                    input logic [4:0] rd, input logic rw, input logic m2r,
                                    input logic mw, input logic br, input logic z,
                                    input logic [31:0] pcb);
        e_m_reg_t x;
        x            = '0;
        x.pc_plus_4  = 32'h0000_2004;
        x.alu_result = alu;
        x.write_data = wdata;
        x.write_reg  = rd;
        x.reg_write  = rw;
        x.mem_to_reg = m2r;
        x.mem_write  = mw;
        x.branch     = br;
        x.zero       = z;
        x.pc_branch  = pcb;
        return x;
    endfunction

    // Bus slave: addr_ok after addr_wait held cycles, data_ok data_wait cycles later.
    initial begin
        int  a_cnt;
        int  d_cnt;
        logic in_data;
        a_cnt = 0; d_cnt = 0; in_data = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 32'h0;
        forever begin
            @(negedge clk);
            bus.dresp_addr_ok = 1'b0;
            bus.dresp_data_ok = 1'b0;
            bus.dresp_data    = 32'h0;
            if (!reset) begin
                a_cnt = 0; d_cnt = 0; in_data = 1'b0;
            end else if (bus.dreq_valid) begin
                if (a_cnt >= addr_wait) begin
                    bus.dresp_addr_ok = 1'b1;
                    a_cnt = 0;
                    if (data_wait == 0) begin
                        bus.dresp_data_ok = 1'b1;
                        bus.dresp_data    = rd_val;
                    end else begin
                        in_data = 1'b1;
                        d_cnt   = 0;
                    end
                end else begin
                    a_cnt++;
                end
            end else if (in_data) begin
                d_cnt++;
                if (d_cnt >= data_wait) begin
                    bus.dresp_data_ok = 1'b1;
                    bus.dresp_data    = rd_val;
                    in_data = 1'b0;
                end
            end else begin
                a_cnt = 0;
            end
        end
    end

    // Monitor: every request cycle must match the queue head; a falling
    // mem_busy marks DONE, where the writeback bundle is checked.
    initial begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (bus.dreq_valid) begin
                    valid_cycles++;
                    if (exp_req.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req addr=%h required=no request", bus.dreq_addr);
                    end else begin
                        chk("req_addr",   bus.dreq_addr,   exp_req[0].addr);
                        chk("req_write",  bus.dreq_write,  exp_req[0].write);
                        chk("req_strobe", bus.dreq_strobe, exp_req[0].strobe);
                        chk("req_data",   bus.dreq_data,   exp_req[0].data);
                        if (bus.dresp_addr_ok) void'(exp_req.pop_front());
                    end
                end
                if (prev_busy && !mem_busy) begin
                    if (exp_wb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done alu=%h required=no completion", m_w_reg.alu_result);
                    end else begin
                        wb_t w;
                        w = exp_wb.pop_front();
                        chk("wb_read_data",  m_w_reg.read_data,  w.read_data);
                        chk("wb_write_reg",  m_w_reg.write_reg,  w.write_reg);
                        chk("wb_reg_write",  m_w_reg.reg_write,  w.reg_write);
                        chk("wb_mem_to_reg", m_w_reg.mem_to_reg, w.mem_to_reg);
                        chk("wb_alu_result", m_w_reg.alu_result, w.alu_result);
                    end
                end
                prev_busy = mem_busy;
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    // Present one instruction for exactly one capture, then a zero bundle.
    task automatic send(input e_m_reg_t x);
        int n;
        n = 0;
        while (mem_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout waited=%0d required=<200", n);
        end
        e_m_in = x;
        @(negedge clk);
        e_m_in = '0;
    endtask

    // Count cycles with mem_busy high; returns at the negedge of DONE.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (mem_busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout cycles=%0d required=<200", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b0; stall_m = 1'b0; flush_m = 1'b0; e_m_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_dreq_valid", bus.dreq_valid, 1'b0);
        chk("rst_mem_busy",   mem_busy, 1'b0);
        chk("rst_m_w_reg",    {31'b0, |m_w_reg}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Zero-wait load
        addr_wait = 0; data_wait = 0; rd_val = 32'hDEAD_BEEF;
        exp_req.push_back('{32'h0000_0100, 1'b0, 4'b0000, 32'hAAAA_0001});
        exp_wb.push_back('{32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1, 32'h0000_0100});
        send(mk(32'h0000_0100, 32'hAAAA_0001, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        wait_done(cyc);
        chk("lw0_busy_cycles", cyc, 32'd1);
        chk("lw0_read_data",   m_w_reg.read_data, 32'hDEAD_BEEF);
        chk("lw0_mem_to_reg",  m_w_reg.mem_to_reg, 1'b1);

        // Split store
        addr_wait = 2; data_wait = 3; rd_val = 32'h0; valid_cycles = 0;
        exp_req.push_back('{32'h0000_0200, 1'b1, 4'b1111, 32'h1234_5678});
        exp_wb.push_back('{32'h0000_0000, 5'd3, 1'b0, 1'b0, 32'h0000_0200});
        send(mk(32'h0000_0200, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        wait_done(cyc);
        chk("sw_busy_cycles",  cyc, 32'd6);
        chk("sw_valid_cycles", valid_cycles, 32'd3);

        // Flush while busy is ignored; still asserted in DONE it inserts a bubble
        addr_wait = 3; data_wait = 0; rd_val = 32'hCAFE_F00D;
        exp_req.push_back('{32'h0000_0300, 1'b0, 4'b0000, 32'h0});
        exp_wb.push_back('{32'hCAFE_F00D, 5'd10, 1'b1, 1'b1, 32'h0000_0300});
        send(mk(32'h0000_0300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        flush_m = 1'b1;
        e_m_in  = mk(32'h0000_0077, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_done(cyc);
        chk("flush_busy_cycles", cyc, 32'd4);
        chk("flush_busy_wreg",   write_regM, 5'd10);
        @(negedge clk);
        flush_m = 1'b0; e_m_in = '0;
        chk("flush_idle_regw", reg_writeM, 1'b0);
        chk("flush_idle_wreg", write_regM, 5'd0);
        chk("flush_idle_alu",  aluout_fwd, 32'h0);

        // Load, stall in DONE, then back-to-back load
        addr_wait = 0; data_wait = 0; rd_val = 32'h1111_2222;
        exp_req.push_back('{32'h0000_0400, 1'b0, 4'b0000, 32'h0});
        exp_wb.push_back('{32'h1111_2222, 5'd11, 1'b1, 1'b1, 32'h0000_0400});
        send(mk(32'h0000_0400, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        wait_done(cyc);
        chk("lw2_busy_cycles", cyc, 32'd1);
        rd_val = 32'h3333_4444;
        exp_req.push_back('{32'h0000_0404, 1'b0, 4'b0000, 32'h0});
        exp_wb.push_back('{32'h3333_4444, 5'd12, 1'b1, 1'b1, 32'h0000_0404});
        e_m_in  = mk(32'h0000_0404, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        stall_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_read_data", m_w_reg.read_data, 32'h1111_2222);
            chk("stall_wreg",      write_regM, 5'd11);
            chk("stall_busy",      mem_busy, 1'b0);
        end
        stall_m = 1'b0;
        @(negedge clk);
        e_m_in = '0;
        chk("b2b_busy_now", mem_busy, 1'b1);
        wait_done(cyc);
        chk("b2b_busy_cycles", cyc, 32'd1);
        chk("b2b_read_data",   m_w_reg.read_data, 32'h3333_4444);

        // Misaligned load
        send(mk(32'h0000_0102, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        chk("mis_addr_err",  addr_err, 1'b1);
        chk("mis_dreq",      bus.dreq_valid, 1'b0);
        chk("mis_wb_regw",   m_w_reg.reg_write, 1'b0);
        chk("mis_busy",      mem_busy, 1'b0);
        chk("mis_regwriteM", reg_writeM, 1'b1);

        // Branch taken and forwarding
        send(mk(32'h0000_0055, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040));
        chk("beq_pcsrc",     pcsrc, 1'b1);
        chk("beq_pc_branch", pc_branch, 32'h0000_0040);
        chk("beq_aluout",    aluout_fwd, 32'h0000_0055);
        chk("beq_addr_err",  addr_err, 1'b0);

        // Branch not taken, ordinary ALU op
        send(mk(32'h0000_0099, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080));
        chk("add_pcsrc",  pcsrc, 1'b0);
        chk("add_aluout", aluout_fwd, 32'h0000_0099);
        chk("add_wreg",   write_regM, 5'd7);
        chk("add_regw",   reg_writeM, 1'b1);
        chk("add_wb_alu", m_w_reg.alu_result, 32'h0000_0099);
        chk("add_wb_pc4", m_w_reg.pc_plus_4, 32'h0000_2004);
        chk("add_busy",   mem_busy, 1'b0);

        @(negedge clk);
        chk("left_req", exp_req.size(), 32'd0);
        chk("left_wb",  exp_wb.size(), 32'd0);

        // Reset in the middle of an unanswered request
        addr_wait = 20; data_wait = 0; rd_val = 32'h0;
        exp_req.push_back('{32'h0000_0500, 1'b0, 4'b0000, 32'h0});
        send(mk(32'h0000_0500, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0060));
        chk("prerst_busy",  mem_busy, 1'b1);
        chk("prerst_pcsrc", pcsrc, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_dreq",  bus.dreq_valid, 1'b0);
        chk("midrst_busy",  mem_busy, 1'b0);
        chk("midrst_pcsrc", pcsrc, 1'b0);
        chk("midrst_mw",    {31'b0, |m_w_reg}, 32'h0);
        exp_req.delete();
        exp_wb.delete();
        @(negedge clk);
        reset = 1'b1;
        addr_wait = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("postrst_busy", mem_busy, 1'b0);
            chk("postrst_dreq", bus.dreq_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory.md
# memory

Pipeline memory-access stage of the five-stage MIPS core, sitting between execute and writeback. It registers the execute-to-memory bundle, drives the data-bus request/response handshake for `lw`/`sw`, and resolves branches. It returns the forwarding value and the destination register to the hazard unit, and holds the pipeline with `mem_busy` until the bus transaction completes.

## Interface
Parameters: none; all widths come from `common`/`pipes` (u32, creg_addr_t = 5 bits).

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; clears all state
- `e_m_reg`  in  e_m_reg_t  from execute. Fields used: pc_plus_4, alu_result, write_data, write_reg, reg_write, mem_to_reg, mem_write, branch, zero, pc_branch.
- `stall_m`  in  1  hold the internal register
- `flush_m`  in  1  capture a bubble instead of `e_m_reg`
- `dreq_valid`  out  1  bus request valid
- `dreq_write`  out  1  1 = store, 0 = load
- `dreq_addr`  out  32  byte address, word-aligned
- `dreq_strobe`  out  4  byte enables: 4'b1111 for a store, 4'b0000 for a load
- `dreq_data`  out  32  store data
- `dresp_addr_ok`  in  1  request accepted
- `dresp_data_ok`  in  1  read data valid, or write completed
- `dresp_data`  in  32  load data
- `m_w_reg`  out  m_w_reg_t  to writeback. Fields: pc_plus_4, alu_result, read_data, write_reg, reg_write, mem_to_reg.
- `pcsrc`  out  1  branch taken
- `pc_branch`  out  32  branch target
- `aluout_fwd`  out  32  forwarding value; goes to execute_forward_data.aluout
- `write_regM`  out  5  destination register, to hazard unit
- `reg_writeM`  out  1  register-write enable, to hazard unit
- `mem_busy`  out  1  stall request to hazard unit
- `addr_err`  out  1  misaligned memory access in this stage

## Operation
Internal register `m` (e_m_reg_t):
- Loads `e_m_reg` when `capture = !stall_m && !mem_busy`.
- Loads all-zero (a bubble) when `capture && flush_m`.
- `flush_m` has no effect while `mem_busy` is high. An issued request is never cancelled.

Decode of `m`:
- `memop = m.mem_to_reg | m.mem_write`
- `m.mem_write` alone selects store.

FSM states: IDLE, ADDR, DATA, DONE. The next state is computed from the incoming value at each capture:
- The incoming instruction is a memop with `alu_result[1:0]==0` → ADDR.
- Otherwise → IDLE. This includes a misaligned memop, which raises `addr_err` and issues no request.

FSM behaviour by state:
- ADDR:
  - Drive `dreq_valid=1`, `dreq_addr=m.alu_result`, `dreq_write=m.mem_write`, `dreq_data=m.write_data`, strobe as above.
  - `addr_ok && data_ok` → DONE and latch `dresp_data`.
  - `addr_ok` only → DATA.
  - Otherwise stay in ADDR with all request fields held stable.
- DATA: `dreq_valid=0`. On `data_ok` → DONE and latch `dresp_data` into `rdata`.
- DONE: hold until the next capture.
- `data_ok` in IDLE or DONE is ignored.

Combinational outputs:
- `mem_busy = (state==ADDR) || (state==DATA)`
- `addr_err = memop && m.alu_result[1:0]!=0`; while set, `m_w_reg.reg_write` is forced to 0
- `m_w_reg`: fields copied from `m`; `read_data = rdata`
- `pcsrc = m.branch & m.zero`; `pc_branch = m.pc_branch`
- `aluout_fwd = m.alu_result`; `write_regM = m.write_reg`; `reg_writeM = m.reg_write`

Reset (asynchronous, `reset` low):
- `m` = 0, `rdata` = 0, state = IDLE.
- All outputs read 0 immediately. `dreq_valid` drops mid-transaction, with no wait for `addr_ok`.

## Timing
- Non-memory instruction: zero added latency; `m_w_reg` is valid in the cycle after capture.
- Load/store with a zero-wait bus (`addr_ok` and `data_ok` in the first ADDR cycle):
  - `mem_busy` is high for exactly 1 cycle.
  - Load data appears on `m_w_reg.read_data` in the next cycle (DONE).
- General case: `mem_busy` is high for (cycles until `addr_ok`) + (cycles from `addr_ok` until `data_ok`), with a minimum of 1.
- `dreq_valid` is high only in ADDR. It never deasserts before `addr_ok` except on reset.
- Back-to-back memops: capture in DONE goes directly to ADDR, so there is no idle cycle between requests.
- `stall_m` high while in DONE: state and `rdata` hold, and the outputs stay stable.

## Test plan
- Reset:
  - Stimulus: drive `reset` low mid-ADDR.
  - Required: `dreq_valid`, `mem_busy`, `pcsrc` and `m_w_reg` all read 0 in the same cycle; after release, state is IDLE.
- Zero-wait load:
  - Stimulus: `lw` with alu_result=0x100; bus returns addr_ok=data_ok=1, data 0xDEADBEEF in the first cycle.
  - Required: exactly 1 `mem_busy` cycle, strobe 0000; next cycle `read_data`=0xDEADBEEF, `mem_to_reg`=1.
- Split store:
  - Stimulus: `sw` to 0x200 with write_data 0x12345678; addr_ok after 2 cycles, data_ok 3 cycles later.
  - Required: `dreq_valid` high for 3 cycles with stable fields and strobe 1111; `mem_busy` high for 6 cycles.
- Flush and stall:
  - Stimulus: `flush_m` while busy; then `flush_m` while idle; then a load followed by a `stall_m` pulse.
  - Required: flush while busy is ignored; flush while idle captures a bubble (`reg_writeM`=0); a second load issues immediately after DONE, and the DONE outputs hold during the stall.
- Misaligned access:
  - Stimulus: `lw` with alu_result=0x102.
  - Required: `addr_err`=1, no `dreq_valid`, `m_w_reg.reg_write`=0, `mem_busy`=0.
- Branch and forwarding:
  - Stimulus: `beq` with branch=1, zero=1, pc_branch=0x40.
  - Required: `pcsrc`=1, `pc_branch`=0x40, `aluout_fwd` equals the captured alu_result.
